// File: rtl/trdmac_pkg.sv
// Shared types and helpers for the TRDMAC transpose engine.
// The engine walks the matrix in 4x4 tiles using 4-beat INCR bursts.
package trdmac_pkg;

    localparam int unsigned TILE      = 4;
    localparam int unsigned BURST_LEN = 4;

    typedef enum logic [2:0] {
        StIdle,
        StRreq,
        StRdat,
        StWreq,
        StWdat,
        StWrsp,
        StNext
    } state_e;

    // Byte offset of element (row, col) in a W-wide row-major matrix; row*W fits in 12 bits.
    function automatic logic [13:0] byte_offset(input logic [5:0] row, input logic [5:0] col,
                                                input logic [5:0] w);
        logic [11:0] elem;
        elem = ({6'b0, row} * {6'b0, w}) + {6'b0, col};
        return {elem, 2'b00};
    endfunction

endpackage

// File: rtl/trdmac_tile_buf.sv
// 4x4 tile buffer: rows are filled by read bursts, columns are read out for write bursts.
// The data array is deliberately left without reset.
module trdmac_tile_buf #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [1:0]        wr_row_i,
    input  logic [1:0]        wr_col_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [1:0]        rd_row_i,
    input  logic [1:0]        rd_col_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [16];
    logic [DATA_W-1:0] mem_d [16];

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[{wr_row_i, wr_col_i}] = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[{rd_row_i, rd_col_i}];

endmodule

// File: rtl/trdmac_engine.sv
// Transpose sequencer: reads 4 source rows of a tile, then writes 4 destination rows,
// each being one column of the buffered source tile.
module trdmac_engine
    import trdmac_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [5:0]        mat_width_i,
    output logic              done_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    output logic [ADDR_W-1:0] araddr_o,
    input  logic              rvalid_i,
    output logic              rready_o,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic              wlast_o,
    input  logic              bvalid_i,
    output logic              bready_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [3:0]        nt_q, nt_d;   // tiles per row, W = nt*4
    logic [3:0]        ty_q, ty_d;
    logic [3:0]        tx_q, tx_d;
    logic [1:0]        r_q, r_d;
    logic [1:0]        c_q, c_d;
    logic [1:0]        k_q, k_d;

    logic              buf_we;
    logic [DATA_W-1:0] buf_rdata;
    logic [13:0]       rd_off;
    logic [13:0]       wr_off;
    logic [3:0]        last_t;
    logic              unused_mw;

    // Width LSBs are dropped: only whole tiles are transposed.
    assign unused_mw = ^mat_width_i[1:0];
    assign last_t    = 4'(nt_q - 4'd1);

    always_comb begin
        rd_off = byte_offset({ty_q, r_q}, {tx_q, 2'b00}, {nt_q, 2'b00});
        wr_off = byte_offset({tx_q, c_q}, {ty_q, 2'b00}, {nt_q, 2'b00});
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        nt_d    = nt_q;
        ty_d    = ty_q;
        tx_d    = tx_q;
        r_d     = r_q;
        c_d     = c_q;
        k_d     = k_q;
        buf_we  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i && (mat_width_i[5:2] != 4'd0)) begin
                    src_d   = src_addr_i;
                    dst_d   = dst_addr_i;
                    nt_d    = mat_width_i[5:2];
                    ty_d    = '0;
                    tx_d    = '0;
                    r_d     = '0;
                    c_d     = '0;
                    k_d     = '0;
                    state_d = StRreq;
                end
            end
            StRreq: begin
                if (arready_i) begin
                    k_d     = '0;
                    state_d = StRdat;
                end
            end
            StRdat: begin
                if (rvalid_i) begin
                    buf_we = 1'b1;
                    k_d    = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        r_d     = r_q + 2'd1;
                        c_d     = '0;
                        state_d = (r_q == 2'd3) ? StWreq : StRreq;
                    end
                end
            end
            StWreq: begin
                if (awready_i) begin
                    k_d     = '0;
                    state_d = StWdat;
                end
            end
            StWdat: begin
                if (wready_i) begin
                    k_d = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        state_d = StWrsp;
                    end
                end
            end
            StWrsp: begin
                if (bvalid_i) begin
                    c_d     = c_q + 2'd1;
                    state_d = (c_q == 2'd3) ? StNext : StWreq;
                end
            end
            StNext: begin
                state_d = StRreq;
                if (tx_q == last_t) begin
                    tx_d = '0;
                    if (ty_q == last_t) begin
                        state_d = StIdle;
                    end else begin
                        ty_d = ty_q + 4'd1;
                    end
                end else begin
                    tx_d = tx_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            nt_q    <= '0;
            ty_q    <= '0;
            tx_q    <= '0;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            nt_q    <= nt_d;
            ty_q    <= ty_d;
            tx_q    <= tx_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
        end
    end

    trdmac_tile_buf #(
        .DATA_W (DATA_W)
    ) u_tile_buf (
        .clk      (clk),
        .we_i     (buf_we),
        .wr_row_i (r_q),
        .wr_col_i (k_q),
        .wdata_i  (rdata_i),
        .rd_row_i (k_q),
        .rd_col_i (c_q),
        .rdata_o  (buf_rdata)
    );

    // Outputs decode from the registered state so they hold steady through stalls.
    assign done_o    = (state_q == StIdle);
    assign arvalid_o = (state_q == StRreq);
    assign rready_o  = (state_q == StRdat);
    assign awvalid_o = (state_q == StWreq);
    assign wvalid_o  = (state_q == StWdat);
    assign bready_o  = (state_q == StWrsp);
    assign wlast_o   = wvalid_o && (k_q == 2'd3);
    assign araddr_o  = arvalid_o ? (src_q + ADDR_W'(rd_off)) : '0;
    assign awaddr_o  = awvalid_o ? (dst_q + ADDR_W'(wr_off)) : '0;
    assign wdata_o   = wvalid_o ? buf_rdata : '0;

endmodule

// File: tb/tb_trdmac_engine.sv
// Self-checking bench for trdmac_engine: a negedge-driven memory slave with optional
// random stalls, and queues of expected AR/AW addresses and write beats.
module tb_trdmac_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] src_addr_i = '0;
    logic [31:0] dst_addr_i = '0;
    logic [5:0]  mat_width_i = '0;
    logic        done_o;
    logic        arvalid_o;
    logic        arready_i = 1'b0;
    logic [31:0] araddr_o;
    logic        rvalid_i = 1'b0;
    logic        rready_o;
    logic [31:0] rdata_i = '0;
    logic        awvalid_o;
    logic        awready_i = 1'b0;
    logic [31:0] awaddr_o;
    logic        wvalid_o;
    logic        wready_i = 1'b0;
    logic [31:0] wdata_o;
    logic        wlast_o;
    logic        bvalid_i = 1'b0;
    logic        bready_o;

    trdmac_engine #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .src_addr_i  (src_addr_i),
        .dst_addr_i  (dst_addr_i),
        .mat_width_i (mat_width_i),
        .done_o      (done_o),
        .arvalid_o   (arvalid_o),
        .arready_i   (arready_i),
        .araddr_o    (araddr_o),
        .rvalid_i    (rvalid_i),
        .rready_o    (rready_o),
        .rdata_i     (rdata_i),
        .awvalid_o   (awvalid_o),
        .awready_i   (awready_i),
        .awaddr_o    (awaddr_o),
        .wvalid_o    (wvalid_o),
        .wready_i    (wready_i),
        .wdata_o     (wdata_o),
        .wlast_o     (wlast_o),
        .bvalid_i    (bvalid_i),
        .bready_o    (bready_o)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [31:0] mem [0:4095];
    logic [31:0] ar_q[$];
    logic [31:0] aw_q[$];
    logic [31:0] w_q[$];
    int          ar_extra = 0;
    int          aw_extra = 0;
    int          w_extra  = 0;
    int          ar_seen  = 0;
    bit          stall    = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit rdy();
        return stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    // Memory slave state
    int          rd_beats = 0;
    int          wr_beat = 0;
    logic [31:0] rd_addr = '0;
    logic [31:0] wr_addr = '0;
    bit          r_fired, b_fired, wr_active, b_pend;
    bit          ar_hold, aw_hold, w_hold;
    logic [31:0] ar_hold_addr, aw_hold_addr, w_hold_data;
    logic        w_hold_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            arready_i = 1'b0;
            rvalid_i  = 1'b0;
            awready_i = 1'b0;
            wready_i  = 1'b0;
            bvalid_i  = 1'b0;
            rd_beats  = 0;
            wr_active = 1'b0;
            b_pend    = 1'b0;
            r_fired   = 1'b0;
            b_fired   = 1'b0;
            ar_hold   = 1'b0;
            aw_hold   = 1'b0;
            w_hold    = 1'b0;
        end else begin
            if (ar_hold) begin
                check_val("ar_stable_valid", arvalid_o, 1);
                check_val("ar_stable_addr", araddr_o, ar_hold_addr);
            end
            if (aw_hold) begin
                check_val("aw_stable_valid", awvalid_o, 1);
                check_val("aw_stable_addr", awaddr_o, aw_hold_addr);
            end
            if (w_hold) begin
                check_val("w_stable_valid", wvalid_o, 1);
                check_val("w_stable_data", wdata_o, w_hold_data);
                check_val("w_stable_last", wlast_o, w_hold_last);
            end
            if (arvalid_o) begin
                ar_seen++;
                check_val("ar_during_write", wr_active | b_pend, 0);
            end

            // R channel
            if (r_fired) rvalid_i = 1'b0;
            if (rd_beats != 0 && !rvalid_i) begin
                rvalid_i = rdy();
                rdata_i  = mem[rd_addr[13:2]];
            end
            r_fired = rvalid_i && rready_o;
            if (r_fired) begin
                rd_addr  = rd_addr + 32'd4;
                rd_beats = rd_beats - 1;
            end

            // AR channel
            arready_i = arvalid_o && rdy();
            if (arvalid_o && arready_i) begin
                if (ar_q.size() == 0) ar_extra++;
                else check_val("araddr", araddr_o, ar_q.pop_front());
                rd_addr  = araddr_o;
                rd_beats = 4;
            end
            ar_hold      = arvalid_o && !arready_i;
            ar_hold_addr = araddr_o;

            // B channel
            if (b_fired) bvalid_i = 1'b0;
            if (b_pend && !bvalid_i) bvalid_i = rdy();
            b_fired = bvalid_i && bready_o;
            if (b_fired) b_pend = 1'b0;

            // W channel
            wready_i = wvalid_o && wr_active && rdy();
            if (wvalid_o && wready_i) begin
                if (w_q.size() == 0) w_extra++;
                else check_val("wdata", wdata_o, w_q.pop_front());
                check_val("wlast", wlast_o, (wr_beat == 3));
                mem[wr_addr[13:2]] = wdata_o;
                wr_addr = wr_addr + 32'd4;
                wr_beat++;
                if (wr_beat == 4) begin
                    wr_active = 1'b0;
                    b_pend    = 1'b1;
                end
            end
            w_hold      = wvalid_o && !wready_i;
            w_hold_data = wdata_o;
            w_hold_last = wlast_o;

            // AW channel
            awready_i = awvalid_o && rdy();
            if (awvalid_o && awready_i) begin
                if (aw_q.size() == 0) aw_extra++;
                else check_val("awaddr", awaddr_o, aw_q.pop_front());
                wr_addr   = awaddr_o;
                wr_beat   = 0;
                wr_active = 1'b1;
            end
            aw_hold      = awvalid_o && !awready_i;
            aw_hold_addr = awaddr_o;
        end
    end

    task automatic start_xfer(input logic [31:0] src, input logic [31:0] dst,
                              input logic [5:0] mw);
        int nt = int'(mw) / 4;
        int w  = nt * 4;
        int sb = int'(src >> 2);
        for (int ty = 0; ty < nt; ty++) begin
            for (int tx = 0; tx < nt; tx++) begin
                for (int r = 0; r < 4; r++)
                    ar_q.push_back(src + 32'(((ty * 4 + r) * w + tx * 4) * 4));
                for (int c = 0; c < 4; c++) begin
                    aw_q.push_back(dst + 32'(((tx * 4 + c) * w + ty * 4) * 4));
                    for (int k = 0; k < 4; k++)
                        w_q.push_back(mem[sb + (ty * 4 + k) * w + tx * 4 + c]);
                end
            end
        end
        @(negedge clk);
        start_i     = 1'b1;
        src_addr_i  = src;
        dst_addr_i  = dst;
        mat_width_i = mw;
        @(negedge clk);
        start_i = 1'b0;
        check_val("done_after_start", done_o, (nt == 0));
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (done_o !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check_val(tag, done_o, 1);
        check_val("ar_left", ar_q.size(), 0);
        check_val("aw_left", aw_q.size(), 0);
        check_val("w_left", w_q.size(), 0);
        check_val("ar_extra", ar_extra, 0);
        check_val("aw_extra", aw_extra, 0);
        check_val("w_extra", w_extra, 0);
    endtask

    task automatic check_transpose(input logic [31:0] src, input logic [31:0] dst, input int w);
        int sb = int'(src >> 2);
        int db = int'(dst >> 2);
        for (int i = 0; i < w; i++)
            for (int j = 0; j < w; j++)
                check_val("xpose", mem[db + j * w + i], mem[sb + i * w + j]);
    endtask

    task automatic fill_src(input int base, input int n, input bit rnd);
        for (int i = 0; i < n; i++) mem[base + i] = rnd ? $urandom : 32'(i);
    endtask

    initial begin
        int seen0;
        int cyc;
        for (int i = 0; i < 4096; i++) mem[i] = 32'hDEAD_0000 | 32'(i);

        repeat (3) @(negedge clk);
        check_val("rst_done", done_o, 1);
        check_val("rst_valids", {arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o}, 0);
        check_val("rst_addr", {araddr_o, awaddr_o}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1) W=4 identity data, no stalls
        fill_src('h400, 16, 1'b0);
        start_xfer(32'h1000, 32'h2000, 6'd4);
        wait_done("t1_done");
        check_transpose(32'h1000, 32'h2000, 4);

        // 2) W=8 random data with random stalls
        stall = 1'b1;
        fill_src('h400, 64, 1'b1);
        start_xfer(32'h1000, 32'h2000, 6'd8);
        wait_done("t2_done");
        check_transpose(32'h1000, 32'h2000, 8);

        // 3) sub-tile widths never start
        for (int m = 0; m < 4; m += 3) begin
            seen0 = ar_seen;
            start_xfer(32'h1000, 32'h2000, 6'(m));
            repeat (20) @(negedge clk);
            check_val("t3_no_ar", ar_seen - seen0, 0);
            check_val("t3_done", done_o, 1);
        end

        // 4) width 6 behaves as width 4
        fill_src('h500, 16, 1'b1);
        mem['hA10] = 32'h5A5A_A5A5;
        start_xfer(32'h1400, 32'h2800, 6'd6);
        wait_done("t4_done");
        check_transpose(32'h1400, 32'h2800, 4);
        check_val("t4_untouched", mem['hA10], 32'h5A5A_A5A5);

        // 5) reset in the middle of a write burst
        fill_src('h400, 64, 1'b1);
        start_xfer(32'h1000, 32'h2000, 6'd8);
        cyc = 0;
        while (!wvalid_o && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check_val("t5_reach_wdat", wvalid_o, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("t5_valids", {arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o}, 0);
        check_val("t5_done", done_o, 1);
        @(negedge clk);
        ar_q.delete();
        aw_q.delete();
        w_q.delete();
        ar_extra = 0;
        aw_extra = 0;
        w_extra  = 0;
        rst_n = 1'b1;
        fill_src('h400, 16, 1'b1);
        start_xfer(32'h1000, 32'h3000, 6'd4);
        wait_done("t5_restart_done");
        check_transpose(32'h1000, 32'h3000, 4);

        // 6) start while busy is ignored
        fill_src('h400, 16, 1'b1);
        start_xfer(32'h1000, 32'h2000, 6'd4);
        repeat (3) @(negedge clk);
        start_i     = 1'b1;
        src_addr_i  = 32'h3000;
        dst_addr_i  = 32'h3800;
        mat_width_i = 6'd8;
        @(negedge clk);
        start_i = 1'b0;
        wait_done("t6_done");
        check_transpose(32'h1000, 32'h2000, 4);
        repeat (10) @(negedge clk);
        check_val("t6_idle", done_o, 1);
        check_val("t6_no_extra_ar", ar_extra, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
